fc_argmax: RTL and testbench

FC_ARGMAX -- requirements
Module: fc_argmax

---
 rtl/fc_argmax_pkg.sv | 16 +
 rtl/fc_argmax.sv | 113 +++++++++++
 tb/tb_fc_argmax.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fc_argmax_pkg.sv
// Shared constants and the state encoding for the FC-layer argmax block.
// Used by fc_argmax; no configuration macros here.
package fc_pkg;

   localparam int FC_SCORE_W   = 38;
   localparam int FC_NUM_CLASS = 10;
   localparam int FC_IDX_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      HOLD,
      REARM
   } fc_state_e;

endpackage

// File: rtl/fc_argmax.sv
// Sequential argmax over the FC neuron outputs. It captures all scores once every neuron is done,
// then scans them with one signed comparator. Optional macro FC_ARGMAX_SCORE_OUT_EN exposes max_score.
module fc_argmax
   import fc_pkg::*;
#(
   parameter int NUM_CLASS = FC_NUM_CLASS,
   parameter int SCORE_W   = FC_SCORE_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_CLASS-1:0][SCORE_W-1:0]   fc_out,
   input  logic [NUM_CLASS-1:0]                fc_done,
   input  logic                                result_ready,
   output logic                                result_valid,
   output logic [FC_IDX_W-1:0]                 class_idx
`ifdef FC_ARGMAX_SCORE_OUT_EN
   ,
   output logic signed [SCORE_W-1:0]           max_score
`endif
);

   localparam logic [FC_IDX_W-1:0] LAST_IDX = FC_IDX_W'(NUM_CLASS - 1);

   fc_state_e                  state_q;
   logic signed [SCORE_W-1:0]  score_q [NUM_CLASS];
   logic signed [SCORE_W-1:0]  best_q, best_d;
   logic [FC_IDX_W-1:0]        best_idx_q, best_idx_d;
   logic [FC_IDX_W-1:0]        idx_q;
   logic                       valid_q;
   logic [FC_IDX_W-1:0]        class_idx_q;
`ifdef FC_ARGMAX_SCORE_OUT_EN
   logic signed [SCORE_W-1:0]  max_score_q;
`endif

   // The single comparator. Both operands are declared signed, so ">" is a signed compare.
   // Strictly greater keeps the earlier index on ties.
   always_comb begin
      best_d     = best_q;
      best_idx_d = best_idx_q;
      if (score_q[idx_q] > best_q) begin
         best_d     = score_q[idx_q];
         best_idx_d = idx_q;
      end
   end

   // NOTE: all state here is updated with non-blocking assignments. Every register then sees the
   // values from before the edge, whatever order the statements are written in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         valid_q     <= 1'b0;
         class_idx_q <= '0;
         idx_q       <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
`ifdef FC_ARGMAX_SCORE_OUT_EN
         max_score_q <= '0;
`endif
         // NOTE: the score array is a set of flops, not a RAM. It must read as zero after reset,
         // so it is cleared here along with the other registers.
         for (int i = 0; i < NUM_CLASS; i++) begin
            score_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (&fc_done) begin
                  for (int i = 0; i < NUM_CLASS; i++) begin
                     score_q[i] <= fc_out[i];
                  end
                  best_q     <= fc_out[0];
                  best_idx_q <= '0;
                  idx_q      <= FC_IDX_W'(1);
                  state_q    <= SCAN;
               end
            end
            SCAN: begin
               best_q     <= best_d;
               best_idx_q <= best_idx_d;
               idx_q      <= idx_q + FC_IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  state_q     <= HOLD;
                  valid_q     <= 1'b1;
                  class_idx_q <= best_idx_d;
`ifdef FC_ARGMAX_SCORE_OUT_EN
                  max_score_q <= best_d;
`endif
               end
            end
            HOLD: begin
               if (result_ready) begin
                  valid_q <= 1'b0;
                  state_q <= REARM;
               end
            end
            REARM: begin
               // Wait for every done flag to drop, so the same inference cannot be captured twice.
               if (~|fc_done) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result_valid = valid_q;
   assign class_idx    = class_idx_q;
`ifdef FC_ARGMAX_SCORE_OUT_EN
   assign max_score    = max_score_q;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax. Expected values are hand-computed per vector.
// The max_score checks are compiled in when FC_ARGMAX_SCORE_OUT_EN is defined.
module tb_fc_argmax;

   localparam int NC = 10;
   localparam int SW = 38;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NC-1:0][SW-1:0]   fc_out;
   logic [NC-1:0]           fc_done;
   logic                    result_ready;
   logic                    result_valid;
   logic [3:0]              class_idx;
`ifdef FC_ARGMAX_SCORE_OUT_EN
   logic signed [SW-1:0]    max_score;
`endif

   int     vec_cnt  = 0;
   int     miss_cnt = 0;
   longint sc [NC];
   longint neg_max;

   fc_argmax dut (
      .clk          (clk),
      .rst          (rst),
      .fc_out       (fc_out),
      .fc_done      (fc_done),
      .result_ready (result_ready),
      .result_valid (result_valid),
`ifdef FC_ARGMAX_SCORE_OUT_EN
      .max_score    (max_score),
`endif
      .class_idx    (class_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_scores();
      for (int i = 0; i < NC; i++) begin
         fc_out[i] = sc[i][SW-1:0];
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raise every done flag, let the next edge capture, then count edges until result_valid.
   task automatic capture_and_wait(input string tag, input int exp_idx, input longint exp_score);
      int n;
      fc_done = '1;
      step();
      n = 0;
      while (!result_valid && n < 40) begin
         step();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'd9);
      check({tag, "_idx"}, 64'(class_idx), 64'(exp_idx));
`ifdef FC_ARGMAX_SCORE_OUT_EN
      check({tag, "_score"}, max_score, exp_score);
`else
      if (exp_score == 0) ;
`endif
   endtask

   // Handshake the result, then drop the done flags so the block goes back to IDLE.
   task automatic release_result(input string tag);
      result_ready = 1'b1;
      step();
      check({tag, "_valid_clr"}, 64'(result_valid), 64'd0);
      result_ready = 1'b0;
      fc_done      = '0;
      step();
   endtask

   initial begin
      int bad;
      int held_idx;
      neg_max      = -(64'sd1 <<< 37);
      rst          = 1'b1;
      fc_done      = '0;
      result_ready = 1'b0;
      fc_out       = '0;
      #1;
      check("rst_valid_async", 64'(result_valid), 64'd0);
      check("rst_idx_async", 64'(class_idx), 64'd0);
      repeat (3) step();
      rst = 1'b0;
      step();
      check("post_rst_valid", 64'(result_valid), 64'd0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
      check("post_rst_score", max_score, 64'd0);
`endif

      // Mixed scores: the maximum is at index 2.
      sc = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 99};
      load_scores();
      capture_and_wait("v_basic", 2, 100);
      release_result("v_basic");

      // Most negative scores: index 6 is one above the others.
      for (int i = 0; i < NC; i++) sc[i] = neg_max;
      sc[6] = neg_max + 1;
      load_scores();
      capture_and_wait("v_neg_edge", 6, neg_max + 1);
      release_result("v_neg_edge");

      // All scores equal: the lowest index wins. result_ready is held high the whole time;
      // it must have no effect before the result is valid.
      for (int i = 0; i < NC; i++) sc[i] = 42;
      load_scores();
      result_ready = 1'b1;
      capture_and_wait("v_all_equal", 0, 42);
      step();
      check("ready_early_clr", 64'(result_valid), 64'd0);
      result_ready = 1'b0;
      fc_done      = '0;
      step();

      // Negative tie between index 1 and index 3: index 1 wins.
      for (int i = 0; i < NC; i++) sc[i] = -10;
      sc[1] = -1;
      sc[3] = -1;
      load_scores();
      capture_and_wait("v_neg_tie", 1, -1);
      release_result("v_neg_tie");

      // Bit 9 of fc_done held low: nothing is captured. Once it rises, the maximum is at the last index.
      for (int i = 0; i < NC - 1; i++) sc[i] = i;
      sc[9] = 1000;
      load_scores();
      fc_done = 10'h1FF;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (result_valid) bad = 1;
      end
      check("partial_done_no_cap", 64'(bad), 64'd0);
      capture_and_wait("v_last_idx", 9, 1000);
      release_result("v_last_idx");

      // HOLD stability: fc_out changes while result_ready stays low.
      sc = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 99};
      load_scores();
      capture_and_wait("hold_a", 2, 100);
      for (int i = 0; i < NC - 1; i++) sc[i] = i;
      sc[9] = 1000;
      load_scores();
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (!result_valid || class_idx != 4'd2) bad = 1;
      end
      check("hold_stable", 64'(bad), 64'd0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
      check("hold_score_stable", max_score, 64'd100);
`endif
      result_ready = 1'b1;
      step();
      check("hold_valid_clr", 64'(result_valid), 64'd0);
      check("hold_idx_kept", 64'(class_idx), 64'd2);
      result_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (result_valid) bad = 1;
      end
      check("rearm_no_recapture", 64'(bad), 64'd0);
      fc_done = '0;
      step();
      capture_and_wait("hold_b", 9, 1000);
      release_result("hold_b");

      // Reset asserted in the middle of a scan (after 4 scan edges).
      held_idx = int'(class_idx);
      check("pre_rst_idx", 64'(held_idx), 64'd9);
      for (int i = 0; i < NC; i++) sc[i] = -10;
      sc[1] = -1;
      sc[3] = -1;
      load_scores();
      fc_done = '1;
      step();
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      check("mid_scan_rst_valid", 64'(result_valid), 64'd0);
      check("mid_scan_rst_idx", 64'(class_idx), 64'd0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
      check("mid_scan_rst_score", max_score, 64'd0);
`endif
      #2 rst = 1'b0;
      capture_and_wait("after_rst", 1, -1);
      release_result("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
